// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: instruction cache FSM states and default geometry.
package mips_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  localparam int ICACHE_LINES = 16;
  localparam int ICACHE_WORDS = 4;

endpackage

// File: rtl/icache_fetch_if.sv
// Word-read refill bus between the instruction cache and the slow instruction memory.
interface icache_fetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );

endinterface

// File: rtl/icache_array.sv
// Tag and data storage for the direct-mapped instruction cache: combinational read, clocked writes.
module icache_array #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAG_W = 24
) (
  input  logic                     clk,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  input  logic [$clog2(WORDS)-1:0] rd_off,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [31:0]              rd_data,
  input  logic                     wr_word_en,
  input  logic                     wr_tag_en,
  input  logic [$clog2(LINES)-1:0] wr_idx,
  input  logic [$clog2(WORDS)-1:0] wr_off,
  input  logic [31:0]              wr_data,
  input  logic [TAG_W-1:0]         wr_tag
);

  logic [TAG_W-1:0] tag_ram  [LINES];
  logic [31:0]      data_ram [LINES*WORDS];

  // Hit must resolve in the same cycle as PCF, so the read port is not registered.
  assign rd_tag  = tag_ram[rd_idx];
  assign rd_data = data_ram[{rd_idx, rd_off}];

  always_ff @(posedge clk) begin
    if (wr_word_en) begin
      data_ram[{wr_idx, wr_off}] <= wr_data;
    end
    if (wr_tag_en) begin
      tag_ram[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache for the fetch stage: combinational hit path, in-order line
// refill over a req/valid handshake, valid bits, and hit/miss performance counters.
module icache_fetch
  import mips_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WORDS = ICACHE_WORDS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    PCF,
  input  logic           InvalidateF,
  output logic [31:0]    InstrF,
  output logic           IStallF,
  icache_fetch_if.master mem,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] pc_idx;
  logic [OFF_W-1:0] pc_off;
  logic             pc_unused;

  icache_state_t    state_reg, state_next;
  logic [OFF_W-1:0] cnt_reg, cnt_next;
  logic [TAG_W-1:0] rtag_reg, rtag_next;
  logic [IDX_W-1:0] ridx_reg, ridx_next;
  logic [LINES-1:0] valid_reg, valid_next;
  logic [31:0]      hit_cnt_reg, miss_cnt_reg;

  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             start;
  logic             word_we;
  logic             fill_done;

  assign pc_tag    = PCF[31 -: TAG_W];
  assign pc_idx    = PCF[2 + OFF_W +: IDX_W];
  assign pc_off    = PCF[2 +: OFF_W];
  assign pc_unused = ^PCF[1:0];

  icache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rd_idx     (pc_idx),
    .rd_off     (pc_off),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_word_en (word_we),
    .wr_tag_en  (fill_done),
    .wr_idx     (ridx_reg),
    .wr_off     (cnt_reg),
    .wr_data    (mem.mem_rdata),
    .wr_tag     (rtag_reg)
  );

  // Hit is evaluated against the live PCF in every state, so a redirect is seen immediately.
  assign hit     = valid_reg[pc_idx] && (rd_tag == pc_tag);
  assign InstrF  = hit ? rd_data : 32'h0;
  assign IStallF = ~hit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rtag_next  = rtag_reg;
    ridx_next  = ridx_reg;
    start      = 1'b0;
    word_we    = 1'b0;
    fill_done  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!hit && !InvalidateF) begin
          start      = 1'b1;
          state_next = REFILL;
          rtag_next  = pc_tag;
          ridx_next  = pc_idx;
          cnt_next   = '0;
        end
      end
      REFILL: begin
        if (mem.mem_valid) begin
          word_we  = 1'b1;
          cnt_next = cnt_reg + OFF_W'(1);
          if (cnt_reg == LAST_OFF) begin
            fill_done  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A completing refill re-arms its own line unless an invalidate lands on the same edge;
  // a starting refill drops its target line so a half-written line can never hit.
  genvar gi;
  for (gi = 0; gi < LINES; gi++) begin : g_valid
    assign valid_next[gi] =
      (fill_done && !InvalidateF && (ridx_reg == IDX_W'(gi))) ? 1'b1 :
      (InvalidateF || (start && (pc_idx == IDX_W'(gi))))      ? 1'b0 :
      valid_reg[gi];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rtag_reg     <= '0;
      ridx_reg     <= '0;
      valid_reg    <= '0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rtag_reg  <= rtag_next;
      ridx_reg  <= ridx_next;
      valid_reg <= valid_next;
      if (state_reg == IDLE && hit) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (start) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign mem.mem_req  = (state_reg == REFILL);
  assign mem.mem_addr = {rtag_reg, ridx_reg, cnt_reg, 2'b00};
  assign hit_cnt      = hit_cnt_reg;
  assign miss_cnt     = miss_cnt_reg;

endmodule
